nco_lut_sched: RTL and testbench

Time-multiplexes one 8-bit-phase sine lookup table across 2**CH_W independent NCO channels. Each channel has its own phase accumulator and frequency tuning word (FTW). On every sample tick the block walks all enabled channels in ascending order, drives the LUT phase, captures the sine value, and streams it out over a valid/ready handshake. It sits between the config register bus and the DAC/mixer stage. The shared LUT is instantiated outside the block as a purely combinational table.

---
 rtl/nco_lut_sched.sv | 103 ++++++++++
 tb/tb_nco_lut_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_lut_sched.sv
// Multi-channel NCO sharing one combinational sine LUT. On every tick the
// enabled channels are walked in ascending order and their samples streamed out.
module nco_lut_sched #(
  parameter int unsigned CH_W  = 2,
  parameter int unsigned ACC_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [ACC_W-1:0]     cfg_ftw,
  input  logic                 cfg_prst,
  input  logic [2**CH_W-1:0]   ch_en,
  output logic [7:0]           lut_phase,
  input  logic [7:0]           lut_val,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_W-1:0]      out_ch,
  output logic [7:0]           out_sample,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int unsigned NCH = 2**CH_W;

  typedef enum logic [1:0] {StIdle, StScan, StLook, StOut} state_e;

  state_e            state;
  logic [CH_W-1:0]   idx;
  logic [ACC_W-1:0]  acc [NCH];
  logic [ACC_W-1:0]  ftw [NCH];
  logic              last_ch;

  assign last_ch = (idx == CH_W'(NCH - 1));
  assign busy    = (state != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      idx        <= '0;
      lut_phase  <= '0;
      out_valid  <= 1'b0;
      out_ch     <= '0;
      out_sample <= '0;
      overrun    <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        ftw[i] <= '0;
      end
    end else begin
      if (cfg_we) ftw[cfg_ch] <= cfg_ftw;

      // Set is evaluated after clear so a coincident overrun wins.
      if (overrun_clr) overrun <= 1'b0;
      if (tick && state != StIdle) overrun <= 1'b1;

      unique case (state)
        StIdle: begin
          if (tick) begin
            idx   <= '0;
            state <= StScan;
          end
        end
        StScan: begin
          if (ch_en[idx]) begin
            lut_phase <= acc[idx][ACC_W-1 -: 8];
            state     <= StLook;
          end else if (last_ch) begin
            state <= StIdle;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        StLook: begin
          out_sample <= lut_val;
          out_ch     <= idx;
          out_valid  <= 1'b1;
          state      <= StOut;
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // ftw[idx] reads the pre-write value when cfg_we hits the same slot.
            acc[idx]  <= acc[idx] + ftw[idx];
            if (last_ch) begin
              state <= StIdle;
            end else begin
              idx   <= idx + 1'b1;
              state <= StScan;
            end
          end
        end
        default: state <= StIdle;
      endcase

      // Placed last so a phase clear overrides a same-cycle accumulate.
      if (cfg_prst) acc[cfg_ch] <= '0;
    end
  end

endmodule

// File: tb/tb_nco_lut_sched.sv
// Bench for nco_lut_sched: directed scenarios plus randomized frames checked
// against a per-channel phase/frequency model and a real-valued sine table.
module tb_nco_lut_sched;

  localparam int CH_W  = 2;
  localparam int ACC_W = 16;
  localparam int NCH   = 2**CH_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tick;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_ftw;
  logic              cfg_prst;
  logic [NCH-1:0]    ch_en;
  logic [7:0]        lut_phase;
  logic [7:0]        lut_val;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [7:0]        out_sample;
  logic              busy;
  logic              overrun;
  logic              overrun_clr;

  logic [7:0]        lut [256];
  logic [ACC_W-1:0]  m_acc [NCH];
  logic [ACC_W-1:0]  m_ftw [NCH];
  int                exp_ch [$];
  logic [7:0]        exp_val [$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign lut_val = lut[lut_phase];

  nco_lut_sched #(
    .CH_W  (CH_W),
    .ACC_W (ACC_W)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_ftw     (cfg_ftw),
    .cfg_prst    (cfg_prst),
    .ch_en       (ch_en),
    .lut_phase   (lut_phase),
    .lut_val     (lut_val),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_sample  (out_sample),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cfg_write(input int ch, input logic [ACC_W-1:0] val);
    @(negedge clk);
    cfg_we  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_ftw = val;
    @(negedge clk);
    cfg_we  = 1'b0;
    m_ftw[ch] = val;
  endtask

  task automatic phase_reset(input int ch);
    @(negedge clk);
    cfg_prst = 1'b1;
    cfg_ch   = CH_W'(ch);
    @(negedge clk);
    cfg_prst = 1'b0;
    m_acc[ch] = '0;
  endtask

  // One tick's worth of samples; expected list comes from the model up front.
  task automatic run_frame(input bit rnd, input int stall, input bit extra, input int prst_ch);
    int en_n = 0;
    int first = -1;
    int first_valid = -1;
    int cyc = 0;
    int busy_cnt = 0;
    int got = 0;
    int stall_left = stall;
    bit hold = 1'b0;
    bit prst_done = 1'b0;
    logic [7:0] hs = '0;
    logic [CH_W-1:0] hc = '0;
    exp_ch.delete();
    exp_val.delete();
    for (int c = 0; c < NCH; c++) begin
      if (ch_en[c]) begin
        if (first < 0) first = c;
        en_n++;
        exp_ch.push_back(c);
        exp_val.push_back(lut[m_acc[c][ACC_W-1 -: 8]]);
        m_acc[c] = m_acc[c] + m_ftw[c];
      end
    end
    @(negedge clk);
    tick      = 1'b1;
    out_ready = 1'b1;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      tick     = extra && (cyc == 2);
      cfg_prst = 1'b0;
      if (!busy && cyc > 2) break;
      if (busy) busy_cnt++;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (hold) begin
        check_eq("hold_sample", 32'(out_sample), 32'(hs));
        check_eq("hold_ch", 32'(out_ch), 32'(hc));
      end
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if (rnd) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      hold = out_valid && !out_ready;
      hs   = out_sample;
      hc   = out_ch;
      if (out_valid && out_ready) begin
        got++;
        if (exp_ch.size() > 0) begin
          check_eq("sample_ch", 32'(out_ch), 32'(exp_ch[0]));
          check_eq("sample_val", 32'(out_sample), 32'(exp_val[0]));
          void'(exp_ch.pop_front());
          void'(exp_val.pop_front());
        end
        if (prst_ch >= 0 && int'(out_ch) == prst_ch) begin
          cfg_ch    = out_ch;
          cfg_prst  = 1'b1;
          prst_done = 1'b1;
        end
      end
    end
    tick     = 1'b0;
    cfg_prst = 1'b0;
    check_eq("frame_done_busy", 32'(busy), 32'(0));
    check_eq("frame_samples", 32'(got), 32'(en_n));
    if (en_n > 0) check_eq("first_latency", 32'(first_valid), 32'(first + 3));
    if (!rnd && stall == 0) check_eq("busy_cycles", 32'(busy_cnt), 32'(3 * en_n + NCH - en_n));
    if (prst_done) m_acc[prst_ch] = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    for (int p = 0; p < 256; p++) begin
      lut[p] = 8'($rtoi(128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * p / 256.0) + 0.5));
    end
    for (int c = 0; c < NCH; c++) begin
      m_acc[c] = '0;
      m_ftw[c] = '0;
    end
    rst_n = 1'b0; tick = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_ftw = '0;
    cfg_prst = 1'b0; ch_en = '0; out_ready = 1'b1; overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_phase", 32'(lut_phase), 32'(0));
    check_eq("rst_sample", 32'(out_sample), 32'(0));
    check_eq("rst_ch", 32'(out_ch), 32'(0));
    check_eq("rst_overrun", 32'(overrun), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Slow ramp on ch0: phase steps by one LUT entry per tick.
    cfg_write(0, 16'h0100);
    ch_en = 4'b0001;
    for (int i = 0; i < 4; i++) run_frame(1'b0, 0, 1'b0, -1);

    // Quadrature steps, then the reverse direction on ch1.
    phase_reset(0);
    cfg_write(0, 16'h4000);
    for (int i = 0; i < 5; i++) run_frame(1'b0, 0, 1'b0, -1);
    ch_en = 4'b0010;
    cfg_write(1, 16'hC000);
    for (int i = 0; i < 4; i++) run_frame(1'b0, 0, 1'b0, -1);

    // Mixed enables with a skipped channel whose phase must not move.
    for (int c = 0; c < NCH; c++) begin
      cfg_write(c, 16'h4000);
      phase_reset(c);
    end
    ch_en = 4'b1011;
    run_frame(1'b0, 0, 1'b0, -1);
    ch_en = 4'b0100;
    run_frame(1'b0, 0, 1'b0, -1);

    // Backpressure on the first sample, then confirm a single advance.
    ch_en = 4'b0001;
    run_frame(1'b0, 7, 1'b0, -1);
    run_frame(1'b0, 0, 1'b0, -1);

    // Tick while busy must flag overrun without starting another frame.
    ch_en = 4'b0011;
    check_eq("ovr_before", 32'(overrun), 32'(0));
    run_frame(1'b0, 0, 1'b1, -1);
    check_eq("ovr_set", 32'(overrun), 32'(1));
    check_eq("ovr_no_frame", 32'(busy), 32'(0));
    @(negedge clk); overrun_clr = 1'b1;
    @(negedge clk); overrun_clr = 1'b0;
    check_eq("ovr_clr", 32'(overrun), 32'(0));

    // Phase clear on ch0's handshake beats the accumulate.
    run_frame(1'b0, 0, 1'b0, 0);
    run_frame(1'b0, 0, 1'b0, -1);

    // Randomized configurations, enables and backpressure.
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 1) == 1) cfg_write($urandom_range(0, NCH - 1), 16'($urandom));
      if ($urandom_range(0, 3) == 0) phase_reset($urandom_range(0, NCH - 1));
      ch_en = NCH'($urandom);
      run_frame(1'b1, 0, 1'b0, ($urandom_range(0, 2) == 0) ? $urandom_range(0, NCH - 1) : -1);
    end

    // Asynchronous reset during ch1's LOOK.
    ch_en     = 4'b0011;
    out_ready = 1'b1;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre_rst_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'(0));
    check_eq("mid_rst_busy", 32'(busy), 32'(0));
    check_eq("mid_rst_phase", 32'(lut_phase), 32'(0));
    check_eq("mid_rst_sample", 32'(out_sample), 32'(0));
    for (int c = 0; c < NCH; c++) begin
      m_acc[c] = '0;
      m_ftw[c] = '0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ch_en = 4'b1111;
    run_frame(1'b0, 0, 1'b0, -1);
    run_frame(1'b0, 0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
